// File: rtl/mem_stage.sv
// MEM pipeline stage: byte-addressed little-endian data memory with
// byte/half/word loads and stores, misalignment detection, one-cycle
// registered write-back outputs and a combinational branch decision.
module mem_stage #(
    parameter int NB_DATA = 32,
    parameter int NB_REG  = 5,
    parameter int NB_PC   = 32,
    parameter int NB_ADDR = 8
) (
    input  logic               i_clock,
    input  logic               i_reset,
    input  logic               i_MEM_reg_write,
    input  logic               i_MEM_mem_to_reg,
    input  logic               i_MEM_mem_read,
    input  logic               i_MEM_mem_write,
    input  logic               i_MEM_branch,
    input  logic               i_MEM_zero,
    input  logic [NB_PC-1:0]   i_MEM_branch_address,
    input  logic [NB_DATA-1:0] i_MEM_alu_result,
    input  logic [NB_DATA-1:0] i_MEM_write_data,
    input  logic [NB_REG-1:0]  i_MEM_selected_reg,
    input  logic [1:0]         i_MEM_size,
    input  logic               i_MEM_unsigned,
    output logic               o_MEM_pc_src,
    output logic [NB_PC-1:0]   o_MEM_branch_address,
    output logic               o_WB_reg_write,
    output logic               o_WB_mem_to_reg,
    output logic [NB_DATA-1:0] o_WB_mem_data,
    output logic [NB_DATA-1:0] o_WB_alu_result,
    output logic [NB_REG-1:0]  o_WB_selected_reg,
    output logic               o_WB_misaligned
);

    localparam int DEPTH = 1 << NB_ADDR;

    // Word storage; never cleared so data survives a reset.
    logic [NB_DATA-1:0] mem_q [DEPTH];

    logic [NB_ADDR-1:0] word_idx;
    logic [1:0]         byte_lane;
    logic [NB_DATA-1:0] rd_word;
    logic [NB_DATA-1:0] wr_word;
    logic               size_misaligned;
    logic               mem_we;
    logic [7:0]         load_byte;
    logic [15:0]        load_half;
    logic [NB_DATA-1:0] load_ext;

    logic               reg_write_d,    reg_write_q;
    logic               mem_to_reg_d,   mem_to_reg_q;
    logic [NB_DATA-1:0] mem_data_d,     mem_data_q;
    logic [NB_DATA-1:0] alu_result_d,   alu_result_q;
    logic [NB_REG-1:0]  selected_reg_d, selected_reg_q;
    logic               misaligned_d,   misaligned_q;

    // Upper address bits beyond the memory are ignored, so accesses wrap.
    assign word_idx  = i_MEM_alu_result[NB_ADDR+1:2];
    assign byte_lane = i_MEM_alu_result[1:0];
    assign rd_word   = mem_q[word_idx];

    // Branch decision goes straight back to IF, untouched by reset.
    assign o_MEM_pc_src         = i_MEM_branch & i_MEM_zero;
    assign o_MEM_branch_address = i_MEM_branch_address;

    // Halves must sit on even addresses, words (size 10 or 11) on multiples of four.
    always_comb begin
        size_misaligned = 1'b0;
        case (i_MEM_size)
            2'b00:   size_misaligned = 1'b0;
            2'b01:   size_misaligned = byte_lane[0];
            default: size_misaligned = (byte_lane != 2'b00);
        endcase
    end

    // Merge store data into the current word, replacing only the addressed lanes.
    always_comb begin
        wr_word = rd_word;
        case (i_MEM_size)
            2'b00: begin
                case (byte_lane)
                    2'd0:    wr_word[7:0]   = i_MEM_write_data[7:0];
                    2'd1:    wr_word[15:8]  = i_MEM_write_data[7:0];
                    2'd2:    wr_word[23:16] = i_MEM_write_data[7:0];
                    default: wr_word[31:24] = i_MEM_write_data[7:0];
                endcase
            end
            2'b01: begin
                if (byte_lane[1]) wr_word[31:16] = i_MEM_write_data[15:0];
                else              wr_word[15:0]  = i_MEM_write_data[15:0];
            end
            default: wr_word = i_MEM_write_data;
        endcase
        mem_we = i_MEM_mem_write & ~size_misaligned;
    end

    // Pick the addressed byte/half out of the pre-write word and extend it.
    always_comb begin
        case (byte_lane)
            2'd0:    load_byte = rd_word[7:0];
            2'd1:    load_byte = rd_word[15:8];
            2'd2:    load_byte = rd_word[23:16];
            default: load_byte = rd_word[31:24];
        endcase
        load_half = byte_lane[1] ? rd_word[31:16] : rd_word[15:0];
        case (i_MEM_size)
            2'b00: load_ext = i_MEM_unsigned ? {{(NB_DATA-8){1'b0}}, load_byte}
                                             : {{(NB_DATA-8){load_byte[7]}}, load_byte};
            2'b01: load_ext = i_MEM_unsigned ? {{(NB_DATA-16){1'b0}}, load_half}
                                             : {{(NB_DATA-16){load_half[15]}}, load_half};
            default: load_ext = rd_word;
        endcase
    end

    // Next write-back values; non-loads and misaligned loads return zero.
    always_comb begin
        reg_write_d    = i_MEM_reg_write;
        mem_to_reg_d   = i_MEM_mem_to_reg;
        alu_result_d   = i_MEM_alu_result;
        selected_reg_d = i_MEM_selected_reg;
        mem_data_d     = '0;
        if (i_MEM_mem_read && !size_misaligned) begin
            mem_data_d = load_ext;
        end
        misaligned_d = (i_MEM_mem_read | i_MEM_mem_write) & size_misaligned;
    end

    // Store port; a store seen while reset is held is dropped.
    always_ff @(posedge i_clock) begin
        if (!i_reset && mem_we) begin
            mem_q[word_idx] <= wr_word;
        end
    end

    // Write-back registers, cleared asynchronously by reset.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            reg_write_q    <= 1'b0;
            mem_to_reg_q   <= 1'b0;
            mem_data_q     <= '0;
            alu_result_q   <= '0;
            selected_reg_q <= '0;
            misaligned_q   <= 1'b0;
        end else begin
            reg_write_q    <= reg_write_d;
            mem_to_reg_q   <= mem_to_reg_d;
            mem_data_q     <= mem_data_d;
            alu_result_q   <= alu_result_d;
            selected_reg_q <= selected_reg_d;
            misaligned_q   <= misaligned_d;
        end
    end

    assign o_WB_reg_write    = reg_write_q;
    assign o_WB_mem_to_reg   = mem_to_reg_q;
    assign o_WB_mem_data     = mem_data_q;
    assign o_WB_alu_result   = alu_result_q;
    assign o_WB_selected_reg = selected_reg_q;
    assign o_WB_misaligned   = misaligned_q;

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: each access pushes its expected
// write-back values onto a scoreboard, popped one cycle later and compared.
module tb_mem_stage;

    localparam int NB_DATA = 32;
    localparam int NB_REG  = 5;
    localparam int NB_PC   = 32;
    localparam int NB_ADDR = 8;

    logic               i_clock;
    logic               i_reset;
    logic               i_MEM_reg_write;
    logic               i_MEM_mem_to_reg;
    logic               i_MEM_mem_read;
    logic               i_MEM_mem_write;
    logic               i_MEM_branch;
    logic               i_MEM_zero;
    logic [NB_PC-1:0]   i_MEM_branch_address;
    logic [NB_DATA-1:0] i_MEM_alu_result;
    logic [NB_DATA-1:0] i_MEM_write_data;
    logic [NB_REG-1:0]  i_MEM_selected_reg;
    logic [1:0]         i_MEM_size;
    logic               i_MEM_unsigned;
    logic               o_MEM_pc_src;
    logic [NB_PC-1:0]   o_MEM_branch_address;
    logic               o_WB_reg_write;
    logic               o_WB_mem_to_reg;
    logic [NB_DATA-1:0] o_WB_mem_data;
    logic [NB_DATA-1:0] o_WB_alu_result;
    logic [NB_REG-1:0]  o_WB_selected_reg;
    logic               o_WB_misaligned;

    mem_stage #(
        .NB_DATA(NB_DATA), .NB_REG(NB_REG), .NB_PC(NB_PC), .NB_ADDR(NB_ADDR)
    ) dut (
        .i_clock(i_clock),
        .i_reset(i_reset),
        .i_MEM_reg_write(i_MEM_reg_write),
        .i_MEM_mem_to_reg(i_MEM_mem_to_reg),
        .i_MEM_mem_read(i_MEM_mem_read),
        .i_MEM_mem_write(i_MEM_mem_write),
        .i_MEM_branch(i_MEM_branch),
        .i_MEM_zero(i_MEM_zero),
        .i_MEM_branch_address(i_MEM_branch_address),
        .i_MEM_alu_result(i_MEM_alu_result),
        .i_MEM_write_data(i_MEM_write_data),
        .i_MEM_selected_reg(i_MEM_selected_reg),
        .i_MEM_size(i_MEM_size),
        .i_MEM_unsigned(i_MEM_unsigned),
        .o_MEM_pc_src(o_MEM_pc_src),
        .o_MEM_branch_address(o_MEM_branch_address),
        .o_WB_reg_write(o_WB_reg_write),
        .o_WB_mem_to_reg(o_WB_mem_to_reg),
        .o_WB_mem_data(o_WB_mem_data),
        .o_WB_alu_result(o_WB_alu_result),
        .o_WB_selected_reg(o_WB_selected_reg),
        .o_WB_misaligned(o_WB_misaligned)
    );

    typedef struct {
        logic        rd;
        logic        wr;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_data;
        logic        exp_mis;
    } stim_t;

    typedef struct {
        logic [31:0] data;
        logic        mis;
        logic [38:0] ctl;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    initial i_clock = 1'b0;
    always #5 i_clock = ~i_clock;

    function automatic stim_t mk(input logic rd, input logic wr, input logic [1:0] size,
                                 input logic uns, input logic [31:0] addr,
                                 input logic [31:0] wdata, input logic [31:0] exp_data,
                                 input logic exp_mis);
        stim_t s;
        s.rd = rd; s.wr = wr; s.size = size; s.uns = uns; s.addr = addr;
        s.wdata = wdata; s.exp_data = exp_data; s.exp_mis = exp_mis;
        return s;
    endfunction

    // Present one access with random pass-through controls, queue its expectation, clock it.
    task automatic drive_access(input stim_t s);
        exp_t e;
        i_MEM_mem_read     = s.rd;
        i_MEM_mem_write    = s.wr;
        i_MEM_size         = s.size;
        i_MEM_unsigned     = s.uns;
        i_MEM_alu_result   = s.addr;
        i_MEM_write_data   = s.wdata;
        i_MEM_reg_write    = 1'($urandom);
        i_MEM_mem_to_reg   = 1'($urandom);
        i_MEM_selected_reg = 5'($urandom);
        e.data = s.exp_data;
        e.mis  = s.exp_mis;
        e.ctl  = {i_MEM_reg_write, i_MEM_mem_to_reg, i_MEM_selected_reg, i_MEM_alu_result};
        sb.push_back(e);
        @(posedge i_clock);
        #1;
    endtask

    task automatic test_reset();
        i_reset = 1'b0;
        i_MEM_branch = 1'b0; i_MEM_zero = 1'b0; i_MEM_branch_address = '0;
        i_MEM_reg_write = 1'b1; i_MEM_mem_to_reg = 1'b1; i_MEM_mem_read = 1'b1;
        i_MEM_mem_write = 1'b0; i_MEM_size = 2'b11; i_MEM_unsigned = 1'b0;
        i_MEM_alu_result = 32'h13; i_MEM_write_data = 32'hFFFF_FFFF;
        i_MEM_selected_reg = 5'h1F;
        #1 i_reset = 1'b1;
        repeat (2) @(posedge i_clock);
        #1;
        n_checks++;
        if ({o_WB_reg_write, o_WB_mem_to_reg, o_WB_selected_reg, o_WB_alu_result} !== 39'h0) begin
            n_fail++;
            $display("[TB] FAIL reset_ctl: got %h expected 0",
                     {o_WB_reg_write, o_WB_mem_to_reg, o_WB_selected_reg, o_WB_alu_result});
        end
        n_checks++;
        if (o_WB_mem_data !== 32'h0) begin
            n_fail++; $display("[TB] FAIL reset_mem_data: got %h expected 0", o_WB_mem_data);
        end
        n_checks++;
        if (o_WB_misaligned !== 1'b0) begin
            n_fail++; $display("[TB] FAIL reset_misaligned: got %b expected 0", o_WB_misaligned);
        end
        // Branch path must work while reset is held.
        i_MEM_branch = 1'b1; i_MEM_zero = 1'b1; i_MEM_branch_address = 32'hCAFE_0040;
        #1;
        n_checks++;
        if ({o_MEM_pc_src, o_MEM_branch_address} !== {1'b1, 32'hCAFE_0040}) begin
            n_fail++;
            $display("[TB] FAIL reset_branch: got %b/%h expected 1/cafe0040",
                     o_MEM_pc_src, o_MEM_branch_address);
        end
        i_MEM_branch = 1'b0; i_MEM_zero = 1'b0;
        @(posedge i_clock);
        #1 i_reset = 1'b0;
    endtask

    task automatic test_word_access();
        stim_t tbl[$];
        exp_t  e;
        tbl.push_back(mk(0, 1, 2'b10, 0, 32'h10, 32'h8000_00F1, 32'h0, 0));
        tbl.push_back(mk(1, 0, 2'b10, 0, 32'h10, 32'h0, 32'h8000_00F1, 0));
        tbl.push_back(mk(1, 0, 2'b00, 0, 32'h10, 32'h0, 32'hFFFF_FFF1, 0));
        tbl.push_back(mk(1, 0, 2'b00, 1, 32'h10, 32'h0, 32'h0000_00F1, 0));
        tbl.push_back(mk(1, 0, 2'b01, 0, 32'h12, 32'h0, 32'hFFFF_8000, 0));
        tbl.push_back(mk(1, 0, 2'b01, 1, 32'h12, 32'h0, 32'h0000_8000, 0));
        tbl.push_back(mk(1, 0, 2'b00, 0, 32'h13, 32'h0, 32'hFFFF_FF80, 0));
        tbl.push_back(mk(0, 1, 2'b00, 0, 32'h11, 32'h5555_55AB, 32'h0, 0));
        tbl.push_back(mk(1, 0, 2'b10, 0, 32'h10, 32'h0, 32'h8000_ABF1, 0));
        tbl.push_back(mk(1, 0, 2'b10, 0, 32'h410, 32'h0, 32'h8000_ABF1, 0));
        foreach (tbl[i]) begin
            drive_access(tbl[i]);
            e = sb.pop_front();
            n_checks++;
            if (o_WB_mem_data !== e.data) begin
                n_fail++; $display("[TB] FAIL word[%0d] mem_data: got %h expected %h", i, o_WB_mem_data, e.data);
            end
            n_checks++;
            if (o_WB_misaligned !== e.mis) begin
                n_fail++; $display("[TB] FAIL word[%0d] misaligned: got %b expected %b", i, o_WB_misaligned, e.mis);
            end
            n_checks++;
            if ({o_WB_reg_write, o_WB_mem_to_reg, o_WB_selected_reg, o_WB_alu_result} !== e.ctl) begin
                n_fail++;
                $display("[TB] FAIL word[%0d] ctl: got %h expected %h", i,
                         {o_WB_reg_write, o_WB_mem_to_reg, o_WB_selected_reg, o_WB_alu_result}, e.ctl);
            end
        end
    endtask

    task automatic test_misaligned();
        stim_t tbl[$];
        exp_t  e;
        tbl.push_back(mk(0, 1, 2'b10, 0, 32'h12, 32'hDEAD_BEEF, 32'h0, 1));
        tbl.push_back(mk(1, 0, 2'b10, 0, 32'h10, 32'h0, 32'h8000_ABF1, 0));
        tbl.push_back(mk(1, 0, 2'b01, 0, 32'h13, 32'h0, 32'h0, 1));
        tbl.push_back(mk(0, 1, 2'b01, 0, 32'h11, 32'h0000_1234, 32'h0, 1));
        tbl.push_back(mk(1, 0, 2'b11, 0, 32'h11, 32'h0, 32'h0, 1));
        tbl.push_back(mk(0, 0, 2'b10, 0, 32'h13, 32'h0, 32'h0, 0));
        tbl.push_back(mk(1, 0, 2'b10, 0, 32'h10, 32'h0, 32'h8000_ABF1, 0));
        foreach (tbl[i]) begin
            drive_access(tbl[i]);
            e = sb.pop_front();
            n_checks++;
            if (o_WB_mem_data !== e.data) begin
                n_fail++; $display("[TB] FAIL misal[%0d] mem_data: got %h expected %h", i, o_WB_mem_data, e.data);
            end
            n_checks++;
            if (o_WB_misaligned !== e.mis) begin
                n_fail++; $display("[TB] FAIL misal[%0d] misaligned: got %b expected %b", i, o_WB_misaligned, e.mis);
            end
        end
    endtask

    task automatic test_back_to_back();
        stim_t tbl[$];
        exp_t  e;
        tbl.push_back(mk(0, 1, 2'b10, 0, 32'h20, 32'h1111_1111, 32'h0, 0));
        tbl.push_back(mk(1, 1, 2'b10, 0, 32'h20, 32'h2222_2222, 32'h1111_1111, 0));
        tbl.push_back(mk(1, 0, 2'b10, 0, 32'h20, 32'h0, 32'h2222_2222, 0));
        tbl.push_back(mk(0, 1, 2'b01, 0, 32'h22, 32'h1234_BEEF, 32'h0, 0));
        tbl.push_back(mk(1, 0, 2'b11, 0, 32'h20, 32'h0, 32'hBEEF_2222, 0));
        tbl.push_back(mk(1, 0, 2'b01, 1, 32'h22, 32'h0, 32'h0000_BEEF, 0));
        tbl.push_back(mk(1, 0, 2'b01, 0, 32'h20, 32'h0, 32'h0000_2222, 0));
        tbl.push_back(mk(1, 0, 2'b00, 0, 32'h23, 32'h0, 32'hFFFF_FFBE, 0));
        tbl.push_back(mk(1, 1, 2'b00, 1, 32'h20, 32'hFFFF_FF99, 32'h0000_0022, 0));
        tbl.push_back(mk(1, 0, 2'b10, 0, 32'h420, 32'h0, 32'hBEEF_2299, 0));
        foreach (tbl[i]) begin
            drive_access(tbl[i]);
            e = sb.pop_front();
            n_checks++;
            if (o_WB_mem_data !== e.data) begin
                n_fail++; $display("[TB] FAIL b2b[%0d] mem_data: got %h expected %h", i, o_WB_mem_data, e.data);
            end
            n_checks++;
            if (o_WB_misaligned !== e.mis) begin
                n_fail++; $display("[TB] FAIL b2b[%0d] misaligned: got %b expected %b", i, o_WB_misaligned, e.mis);
            end
        end
    endtask

    task automatic test_branch();
        logic [1:0]  combo;
        logic [31:0] addr;
        for (int i = 0; i < 4; i++) begin
            combo = 2'(i);
            addr  = $urandom;
            i_MEM_branch = combo[1];
            i_MEM_zero   = combo[0];
            i_MEM_branch_address = addr;
            #1;
            n_checks++;
            if ({o_MEM_pc_src, o_MEM_branch_address} !== {(combo == 2'b11), addr}) begin
                n_fail++;
                $display("[TB] FAIL branch[%0d]: got %b/%h expected %b/%h", i,
                         o_MEM_pc_src, o_MEM_branch_address, (combo == 2'b11), addr);
            end
        end
        i_MEM_branch = 1'b0; i_MEM_zero = 1'b0;
    endtask

    task automatic test_async_reset();
        exp_t e;
        drive_access(mk(1, 0, 2'b10, 0, 32'h10, 32'h0, 32'h8000_ABF1, 0));
        e = sb.pop_front();
        n_checks++;
        if (o_WB_mem_data !== e.data) begin
            n_fail++; $display("[TB] FAIL areset_pre: got %h expected %h", o_WB_mem_data, e.data);
        end
        // Reset lands between edges with a load in flight.
        i_MEM_mem_read = 1'b1; i_MEM_mem_write = 1'b0; i_MEM_size = 2'b10;
        i_MEM_alu_result = 32'h10; i_MEM_reg_write = 1'b1; i_MEM_selected_reg = 5'h7;
        #2 i_reset = 1'b1;
        #1;
        n_checks++;
        if ({o_WB_reg_write, o_WB_mem_to_reg, o_WB_selected_reg, o_WB_alu_result,
             o_WB_mem_data, o_WB_misaligned} !== 72'h0) begin
            n_fail++;
            $display("[TB] FAIL areset_immediate: got data %h alu %h expected 0", o_WB_mem_data, o_WB_alu_result);
        end
        // A store presented during reset must not reach memory.
        i_MEM_mem_write = 1'b1; i_MEM_write_data = 32'h0;
        @(posedge i_clock);
        #1;
        n_checks++;
        if ({o_WB_reg_write, o_WB_alu_result, o_WB_mem_data} !== 65'h0) begin
            n_fail++;
            $display("[TB] FAIL areset_held: got data %h alu %h expected 0", o_WB_mem_data, o_WB_alu_result);
        end
        i_reset = 1'b0;
        drive_access(mk(1, 0, 2'b10, 0, 32'h10, 32'h0, 32'h8000_ABF1, 0));
        e = sb.pop_front();
        n_checks++;
        if (o_WB_mem_data !== e.data) begin
            n_fail++; $display("[TB] FAIL areset_retained: got %h expected %h", o_WB_mem_data, e.data);
        end
    endtask

    initial begin
        test_reset();
        test_word_access();
        test_misaligned();
        test_back_to_back();
        test_branch();
        test_async_reset();
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++; $display("[TB] FAIL scoreboard_drain: got %0d entries expected 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 Parameter NB_DATA, default 32, data and address width.
REQ-002 Parameter NB_REG, default 5, register-index width.
REQ-003 Parameter NB_PC, default 32, PC/branch-address width.
REQ-004 Parameter NB_ADDR, default 8, word-index width; memory depth 2**NB_ADDR words.
REQ-005 The block SHALL have one clock and an asynchronous, active-high reset: i_clock and i_reset.
REQ-006 i_clock  in  1  rising-edge clock.
REQ-007 i_reset  in  1  asynchronous, active-high reset.
REQ-008 i_MEM_reg_write, i_MEM_mem_to_reg  in  1 each  WB control, passed through.
REQ-009 i_MEM_mem_read, i_MEM_mem_write  in  1 each  load / store request.
REQ-010 i_MEM_branch, i_MEM_zero  in  1 each  branch flag and ALU zero from EX.
REQ-011 i_MEM_branch_address  in  NB_PC  branch target from EX.
REQ-012 i_MEM_alu_result  in  NB_DATA  byte address (load/store) or ALU result.
REQ-013 i_MEM_write_data  in  NB_DATA  store data (rt value).
REQ-014 i_MEM_selected_reg  in  NB_REG  destination register.
REQ-015 i_MEM_size  in  2  00 byte, 01 half, 10 word, 11 treated as word.
REQ-016 i_MEM_unsigned  in  1  1 = zero-extend load, 0 = sign-extend.
REQ-017 o_MEM_pc_src  out  1  combinational i_MEM_branch AND i_MEM_zero.
REQ-018 o_MEM_branch_address  out  NB_PC  combinational copy of i_MEM_branch_address.
REQ-019 o_WB_reg_write, o_WB_mem_to_reg  out  1 each  registered controls.
REQ-020 o_WB_mem_data  out  NB_DATA  registered, extended load data.
REQ-021 o_WB_alu_result  out  NB_DATA  registered i_MEM_alu_result.
REQ-022 o_WB_selected_reg  out  NB_REG  registered destination.
REQ-023 o_WB_misaligned  out  1  registered misalignment flag for the access just completed.

Function
REQ-024 Memory SHALL be 2**NB_ADDR words of NB_DATA bits, byte-addressed little-endian; word index = address[NB_ADDR+1:2], upper address bits ignored (wrap-around).
REQ-025 Latency SHALL be one cycle: all o_WB_* outputs update on the rising edge following input presentation; no stalls, one access per cycle.
REQ-026 Store: byte writes lane address[1:0] with write_data[7:0]; half writes lanes {address[1],0} pair with write_data[15:0]; word writes all lanes; other lanes unchanged.
REQ-027 Load: selected byte/half/word extracted per address[1:0], sign- or zero-extended per i_MEM_unsigned, captured into o_WB_mem_data.
REQ-028 Misaligned = (half and address[0]=1) or (word and address[1:0]!=00); a misaligned store SHALL NOT modify memory, a misaligned load SHALL return 0; o_WB_misaligned = 1 for that cycle only.
REQ-029 mem_read=0 SHALL give o_WB_mem_data = 0; o_WB_misaligned only asserts when mem_read or mem_write is 1.
REQ-030 mem_read and mem_write both 1: store performed; load returns pre-write contents (read-before-write).
REQ-031 Load following a store to same word on next cycle SHALL return the newly written data.
REQ-032 o_MEM_pc_src and o_MEM_branch_address SHALL be purely combinational, independent of reset.

Reset
REQ-033 While i_reset=1, all o_WB_* outputs SHALL be 0 immediately (asynchronous) and held 0.
REQ-034 Memory contents SHALL NOT be cleared by reset; stores presented while i_reset=1 SHALL be ignored.
REQ-035 Reset asserted mid-access SHALL abort the access; first valid access is on the first rising edge after deassertion.

Verification
REQ-036 Word store 0x8000_00F1 at 0x10, then lw 0x10 -> o_WB_mem_data = 0x8000_00F1 one cycle later, misaligned=0.
REQ-037 lb 0x10 signed -> 0xFFFF_FFF1; lbu 0x10 -> 0x0000_00F1; lh 0x12 -> 0xFFFF_8000; lhu 0x12 -> 0x0000_8000.
REQ-038 sb 0xAB at 0x11 then lw 0x10 -> 0x8000_ABF1 (other lanes intact).
REQ-039 sw at 0x12 (misaligned) -> o_WB_misaligned=1, subsequent lw 0x10 unchanged; lh 0x13 -> data 0, misaligned=1.
REQ-040 branch=1, zero=1 -> o_MEM_pc_src=1 same cycle, branch_address passed; zero=0 -> pc_src=0.
REQ-041 Assert i_reset between clock edges during a load -> o_WB_* = 0 immediately; memory at 0x10 retained after deassertion.
